// File: rtl/game_pkg.sv
// Shared game definitions: heading encoding, motion FSM states, winner codes
// and the playfield size that the drawing logic also relies on.
package game_pkg;

  localparam int GAME_GRID_W = 64;
  localparam int GAME_GRID_H = 48;
  localparam int POS_W       = 6;

  typedef enum logic [2:0] {
    WAIT  = 3'd0,
    RIGHT = 3'd1,
    DOWN  = 3'd2,
    LEFT  = 3'd3,
    UP    = 3'd4
  } directions;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OVER = 2'd2
  } motion_state_t;

  // Bit 1 set = player 1 lost, bit 0 set = player 2 lost.
  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

endpackage

// File: rtl/step_calc.sv
// Combinational one-cell move for a single player head, with wall detection.
// On a wall hit the position is held so it never leaves the playfield.
module step_calc
  import game_pkg::*;
#(
  parameter int GRID_W = GAME_GRID_W,
  parameter int GRID_H = GAME_GRID_H
) (
  input  directions          dir,
  input  logic [POS_W-1:0]   x,
  input  logic [POS_W-1:0]   y,
  output logic [POS_W-1:0]   nx,
  output logic [POS_W-1:0]   ny,
  output logic               wall
);

  localparam logic [POS_W-1:0] X_MAX = POS_W'(GRID_W - 1);
  localparam logic [POS_W-1:0] Y_MAX = POS_W'(GRID_H - 1);
  localparam logic [POS_W-1:0] ONE   = POS_W'(1);

  always_comb begin
    nx   = x;
    ny   = y;
    wall = 1'b0;
    case (dir)
      RIGHT: if (x == X_MAX) wall = 1'b1; else nx = x + ONE;
      LEFT:  if (x == '0)    wall = 1'b1; else nx = x - ONE;
      DOWN:  if (y == Y_MAX) wall = 1'b1; else ny = y + ONE;
      UP:    if (y == '0)    wall = 1'b1; else ny = y - ONE;
      default: ;
    endcase
  end

endmodule

// File: rtl/player_motion.sv
// Two-player head movement: steps both heads once per STEP_CYCLES clocks while
// running, resolves wall and head-to-head collisions, and latches the winner.
module player_motion
  import game_pkg::*;
#(
  parameter int STEP_CYCLES = 8_125_000,
  parameter int GRID_W      = GAME_GRID_W,
  parameter int GRID_H      = GAME_GRID_H,
  parameter int START_X_1   = 16,
  parameter int START_Y_1   = 24,
  parameter int START_X_2   = 47,
  parameter int START_Y_2   = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  directions         direction_1,
  input  directions         direction_2,
  output logic [POS_W-1:0]  pos_x_1,
  output logic [POS_W-1:0]  pos_y_1,
  output logic [POS_W-1:0]  pos_x_2,
  output logic [POS_W-1:0]  pos_y_2,
  output logic              step_pulse,
  output logic              game_over,
  output logic [1:0]        winner
);

  localparam int CNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  localparam logic [POS_W-1:0] SX1 = POS_W'(START_X_1);
  localparam logic [POS_W-1:0] SY1 = POS_W'(START_Y_1);
  localparam logic [POS_W-1:0] SX2 = POS_W'(START_X_2);
  localparam logic [POS_W-1:0] SY2 = POS_W'(START_Y_2);

  motion_state_t     state, next_state;
  logic [CNT_W-1:0]  tick_cnt;
  logic [POS_W-1:0]  nx1, ny1, nx2, ny2;
  logic              wall_1, wall_2, head, lose_1, lose_2, any_loss, tick;

  step_calc #(.GRID_W(GRID_W), .GRID_H(GRID_H)) u_step_1 (
    .dir (direction_1),
    .x   (pos_x_1),
    .y   (pos_y_1),
    .nx  (nx1),
    .ny  (ny1),
    .wall(wall_1)
  );

  step_calc #(.GRID_W(GRID_W), .GRID_H(GRID_H)) u_step_2 (
    .dir (direction_2),
    .x   (pos_x_2),
    .y   (pos_y_2),
    .nx  (nx2),
    .ny  (ny2),
    .wall(wall_2)
  );

  // Same target cell, or the two heads passing through each other.
  assign head = ((nx1 == nx2) && (ny1 == ny2)) ||
                ((nx1 == pos_x_2) && (ny1 == pos_y_2) &&
                 (nx2 == pos_x_1) && (ny2 == pos_y_1));
  assign lose_1   = wall_1 | head;
  assign lose_2   = wall_2 | head;
  assign any_loss = lose_1 | lose_2;

  // A dropping enable overrides a coincident step.
  assign tick = (state == RUN) && enable && (tick_cnt == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (enable) next_state = RUN;
      RUN: begin
        if (!enable)              next_state = IDLE;
        else if (tick && any_loss) next_state = OVER;
      end
      OVER:    if (!enable) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    game_over = (state == OVER);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt   <= '0;
      pos_x_1    <= SX1;
      pos_y_1    <= SY1;
      pos_x_2    <= SX2;
      pos_y_2    <= SY2;
      step_pulse <= 1'b0;
      winner     <= WIN_NONE;
    end else begin
      step_pulse <= 1'b0;
      if (next_state == IDLE) begin
        tick_cnt <= '0;
        pos_x_1  <= SX1;
        pos_y_1  <= SY1;
        pos_x_2  <= SX2;
        pos_y_2  <= SY2;
        winner   <= WIN_NONE;
      end else if (state == RUN) begin
        if (tick) begin
          tick_cnt <= '0;
          if (any_loss) begin
            winner <= {lose_1, lose_2};
          end else begin
            pos_x_1    <= nx1;
            pos_y_1    <= ny1;
            pos_x_2    <= nx2;
            pos_y_2    <= ny2;
            step_pulse <= 1'b1;
          end
        end else begin
          tick_cnt <= tick_cnt + CNT_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_player_motion.sv
// Bench for player_motion: four instances with different start cells share one
// stimulus stream; a cell-level game model is compared every cycle.
module tb_player_motion;
  import game_pkg::*;

  localparam int SC = 4;
  localparam int N  = 4;
  localparam int M_IDLE = 0, M_RUN = 1, M_OVER = 2;
  localparam int SX1 [N] = '{16, 63, 30, 30};
  localparam int SX2 [N] = '{47, 47, 32, 31};
  localparam int SY  = 24;

  logic      clk = 1'b0;
  logic      rst = 1'b1;
  logic      enable = 1'b0;
  directions direction_1 = WAIT;
  directions direction_2 = WAIT;

  logic [N-1:0][5:0] px1, py1, px2, py2;
  logic [N-1:0]      sp, go;
  logic [N-1:0][1:0] win;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    player_motion #(
      .STEP_CYCLES(SC),
      .START_X_1(SX1[g]), .START_Y_1(SY),
      .START_X_2(SX2[g]), .START_Y_2(SY)
    ) u_dut (
      .clk(clk), .rst(rst), .enable(enable),
      .direction_1(direction_1), .direction_2(direction_2),
      .pos_x_1(px1[g]), .pos_y_1(py1[g]),
      .pos_x_2(px2[g]), .pos_y_2(py2[g]),
      .step_pulse(sp[g]), .game_over(go[g]), .winner(win[g])
    );
  end

  int checks = 0;
  int passes = 0;

  // Game model: plain integer cells, one entry per instance.
  int mst [N], mcnt [N], mx1 [N], my1 [N], mx2 [N], my2 [N], mwin [N];
  bit mp [N];

  function automatic void move(input directions d, input int x, input int y,
                               output int nx, output int ny, output bit wall);
    int dx = 0, dy = 0;
    case (d)
      RIGHT: dx = 1;
      LEFT:  dx = -1;
      DOWN:  dy = 1;
      UP:    dy = -1;
      default: ;
    endcase
    nx = x + dx;
    ny = y + dy;
    wall = (nx < 0) || (nx >= GAME_GRID_W) || (ny < 0) || (ny >= GAME_GRID_H);
    if (wall) begin
      nx = x;
      ny = y;
    end
  endfunction

  function automatic void place_start(input int i);
    mx1[i] = SX1[i]; my1[i] = SY; mx2[i] = SX2[i]; my2[i] = SY;
    mwin[i] = 0; mcnt[i] = 0;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      place_start(i);
      mst[i] = M_IDLE;
      mp[i] = 1'b0;
    end
  endfunction

  function automatic void model_step();
    int n1x, n1y, n2x, n2y;
    bit w1, w2, hd, l1, l2;
    for (int i = 0; i < N; i++) begin
      mp[i] = 1'b0;
      case (mst[i])
        M_IDLE: begin
          place_start(i);
          if (enable) mst[i] = M_RUN;
        end
        M_RUN: begin
          if (!enable) begin
            mst[i] = M_IDLE;
            place_start(i);
          end else if (mcnt[i] == SC - 1) begin
            mcnt[i] = 0;
            move(direction_1, mx1[i], my1[i], n1x, n1y, w1);
            move(direction_2, mx2[i], my2[i], n2x, n2y, w2);
            hd = (n1x == n2x && n1y == n2y) ||
                 (n1x == mx2[i] && n1y == my2[i] && n2x == mx1[i] && n2y == my1[i]);
            l1 = w1 | hd;
            l2 = w2 | hd;
            if (l1 || l2) begin
              mwin[i] = (l1 ? 2 : 0) + (l2 ? 1 : 0);
              mst[i] = M_OVER;
            end else begin
              mx1[i] = n1x; my1[i] = n1y; mx2[i] = n2x; my2[i] = n2y;
              mp[i] = 1'b1;
            end
          end else begin
            mcnt[i] = mcnt[i] + 1;
          end
        end
        default: begin
          if (!enable) begin
            mst[i] = M_IDLE;
            place_start(i);
          end
        end
      endcase
    end
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) model_reset();
    else      model_step();
  end

  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      logic [27:0] e, a;
      e = {6'(mx1[i]), 6'(my1[i]), 6'(mx2[i]), 6'(my2[i]), mp[i],
           (mst[i] == M_OVER), 2'(mwin[i])};
      a = {px1[i], py1[i], px2[i], py2[i], sp[i], go[i], win[i]};
      checks++;
      if (a === e) passes++;
      else $display("FAIL model_u%0d t=%0t got=%h expected=%h", i, $time, a, e);
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s got=%0d expected=%0d", name, got, exp);
  endtask

  int pcnt [N];

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
      for (int i = 0; i < N; i++) pcnt[i] += int'(sp[i]);
    end
  endtask

  task automatic clear_pulses();
    for (int i = 0; i < N; i++) pcnt[i] = 0;
  endtask

  directions dtab [5] = '{WAIT, RIGHT, DOWN, LEFT, UP};

  initial begin
    #1 rst = 1'b0;
    enable = 1'b1;
    #1;
    check("reset_pos_u0", {px1[0], py1[0], px2[0], py2[0]}, {6'd16, 6'd24, 6'd47, 6'd24});
    check("reset_ctl_u0", {sp[0], go[0], win[0]}, 4'b0000);
    check("reset_x1_u1", px1[1], 63);

    @(posedge clk);
    #2 rst = 1'b1;
    clear_pulses();
    run(12);
    check("wait_pulses_u0", pcnt[0], 2);
    check("wait_pos_u0", {px1[0], py1[0], px2[0], py2[0]}, {6'd16, 6'd24, 6'd47, 6'd24});
    check("wait_winner_u0", win[0], 0);

    direction_1 = RIGHT;
    direction_2 = LEFT;
    clear_pulses();
    run(12);
    check("race_pulses_u0", pcnt[0], 3);
    check("race_pos_u0", {px1[0], py1[0], px2[0], py2[0]}, {6'd19, 6'd24, 6'd44, 6'd24});
    check("wall_over_u1", {go[1], win[1]}, {1'b1, 2'b10});
    check("wall_x1_u1", px1[1], 63);
    check("head_win_u2", {go[2], win[2]}, {1'b1, 2'b11});
    check("head_pos_u2", {px1[2], px2[2]}, {6'd30, 6'd32});
    check("head_pulses_u2", pcnt[2], 0);
    check("swap_win_u3", win[3], 3);
    check("swap_pos_u3", {px1[3], px2[3]}, {6'd30, 6'd31});

    enable = 1'b0;
    clear_pulses();
    run(1);
    check("drop_pulse_u0", sp[0], 0);
    check("drop_pos_u0", {px1[0], px2[0]}, {6'd16, 6'd47});
    check("drop_over_u1", {go[1], win[1]}, 3'b000);
    run(3);
    check("idle_pulses_u0", pcnt[0], 0);

    enable = 1'b1;
    for (int i = 0; i < 24; i++) begin
      direction_1 = dtab[(i * 3) % 5];
      direction_2 = dtab[(i * 2 + 1) % 5];
      run(1);
    end

    direction_1 = DOWN;
    direction_2 = UP;
    run(6);
    #1 rst = 1'b0;
    #1;
    check("rst_mid_pos_u0", {px1[0], py1[0], px2[0], py2[0]}, {6'd16, 6'd24, 6'd47, 6'd24});
    check("rst_mid_ctl_u0", {sp[0], go[0], win[0]}, 4'b0000);
    run(2);
    rst = 1'b1;
    run(10);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/player_motion.md
Name: player_motion

Overview:
- Consumes the per-player direction streams produced by the mouse-driven direction controller.
- Advances each player's head one grid cell per step tick.
- Detects wall and head-to-head collisions, then reports game over and the winner.
- Sits between direction control and the drawing/trail logic. Its outputs drive the head sprite coordinates and the trail-write strobe.

Parameters:
- STEP_CYCLES, 8_125_000, clk cycles per movement step.
- GRID_W, 64, playfield width in cells.
- GRID_H, 48, playfield height in cells.
- START_X_1, 16, player 1 start column.
- START_Y_1, 24, player 1 start row.
- START_X_2, 47, player 2 start column.
- START_Y_2, 24, player 2 start row.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-low.
- enable  in  1  game running request (level).
- direction_1  in  directions  player 1 heading (WAIT/RIGHT/DOWN/LEFT/UP).
- direction_2  in  directions  player 2 heading.
- pos_x_1  out  6  player 1 column.
- pos_y_1  out  6  player 1 row.
- pos_x_2  out  6  player 2 column.
- pos_y_2  out  6  player 2 row.
- step_pulse  out  1  one-cycle strobe; positions just advanced.
- game_over  out  1  high while in OVER.
- winner  out  2  00 none, 01 P1 wins, 10 P2 wins, 11 draw.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, tick counter=0.
  - Positions = START_*.
  - step_pulse=0, game_over=0, winner=00.
- States: IDLE, RUN, OVER. All outputs are registered.
- IDLE:
  - Counter held at 0; positions forced to START_*; winner=00.
  - enable=1 moves to RUN on the next edge.
- RUN:
  - Counter increments each cycle.
  - At count==STEP_CYCLES-1, the counter wraps to 0 and a step is evaluated in that cycle.
  - First step therefore occurs STEP_CYCLES cycles after entering RUN.
- Step evaluation, per player:
  - next = cur+1 col (RIGHT), cur-1 col (LEFT), cur+1 row (DOWN), cur-1 row (UP), unchanged (WAIT).
- Wall hit for a player:
  - RIGHT with x==GRID_W-1, LEFT with x==0, DOWN with y==GRID_H-1, or UP with y==0.
  - Positions never wrap and never leave 0..GRID_W-1 / 0..GRID_H-1.
- Head hit is either of:
  - next_1==next_2 (includes moving into a stationary WAIT player);
  - or the players swap cells (next_1==cur_2 and next_2==cur_1).
- Loss flags:
  - lose_1 = wall_1 | head; lose_2 = wall_2 | head.
- No loss at a step:
  - Both positions take their next values.
  - step_pulse=1 for exactly that one cycle, even if both players are WAIT.
- Any loss at a step:
  - Positions are not updated; step_pulse stays 0.
  - winner={lose_1,lose_2}; state moves to OVER.
- OVER:
  - game_over=1; positions and winner frozen; counter stopped.
  - enable=0 moves to IDLE, which restores start positions and clears winner/game_over.
- enable=0 while in RUN: return to IDLE on the next edge, abandoning any pending step.
- Simultaneous enable drop and step tick in RUN: enable wins, so no step and no pulse.
- Direction inputs are sampled only on the tick cycle; changes between ticks have no effect.
- Async reset mid-game: immediate return to reset values; no step_pulse is emitted.

Decomposition:
- game_pkg holds:
  - the directions enum (already shared);
  - a new motion_state_t enum (IDLE/RUN/OVER);
  - the winner encoding constants WIN_NONE/WIN_P1/WIN_P2/WIN_DRAW.
- GRID_W/GRID_H defaults come from game_pkg so drawing logic agrees with them.
- One sub-module, step_calc: purely combinational.
  - Inputs: one direction and one current x/y.
  - Outputs: next x/y and the wall flag.
  - Instantiated twice.
- Tick counter, FSM and collision logic stay in player_motion.

Test Plan (STEP_CYCLES=4):
- Release reset with enable=1 and both directions WAIT:
  - step_pulse fires on cycles 4, 8, …;
  - positions stay at (16,24) and (47,24); winner=00.
- direction_1=RIGHT, direction_2=LEFT for 3 steps:
  - P1 ends at (19,24), P2 at (44,24);
  - exactly 3 step_pulse strobes.
- Start P1 at START_X_1=63 with RIGHT, P2 WAIT:
  - first tick gives game_over=1, winner=10, P1 still at (63,24);
  - enable=0 returns to IDLE with positions reset.
- START_X_1=30, START_X_2=32 (same row), RIGHT/LEFT:
  - first tick gives a head hit on cell 31; winner=11; no step_pulse.
- Adjacent at x=30/31, RIGHT/LEFT:
  - swap is detected as a head hit; winner=11; positions unchanged.
- Drop enable one cycle before a tick in RUN:
  - no step_pulse; state=IDLE; positions at START_*.
- Assert rst mid-RUN:
  - all outputs immediately return to reset values.
